// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: shared types and helpers for the digit-serial ALU.
//   alu_cmd_e     - the 16 command codes (arith 0-7, logic 8-11, reserved 12-15)
//   state_e       - sequencer states IDLE / RUN / DONE
//   is_arith()    - command goes through the adder
//   is_logic()    - command is a bitwise logic op (no carry chain)
//   is_reserved() - command is one of the reserved codes 12-15
package alu_serial_pkg;

  localparam int ALU_CMD_WIDTH = 4;

  typedef enum logic [ALU_CMD_WIDTH-1:0] {
    CMD_TRANSFER   = 4'd0,   // A + 0 + 0
    CMD_INC        = 4'd1,   // A + 0 + 1
    CMD_ADD        = 4'd2,   // A + B + 0
    CMD_ADD_PLUS1  = 4'd3,   // A + B + 1
    CMD_SUB_MINUS1 = 4'd4,   // A + ~B + 0
    CMD_SUB        = 4'd5,   // A + ~B + 1
    CMD_DEC        = 4'd6,   // A + all1 + 0
    CMD_TRANSFER2  = 4'd7,   // A + all1 + 1
    CMD_AND        = 4'd8,
    CMD_OR         = 4'd9,
    CMD_XOR        = 4'd10,
    CMD_NOT        = 4'd11,  // ~A
    CMD_RSV12      = 4'd12,
    CMD_RSV13      = 4'd13,
    CMD_RSV14      = 4'd14,
    CMD_RSV15      = 4'd15
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Arithmetic commands occupy the lower half of the code space.
  function automatic logic is_arith(input alu_cmd_e cmd);
    return (cmd[3] == 1'b0);
  endfunction

  function automatic logic is_logic(input alu_cmd_e cmd);
    return (cmd[3:2] == 2'b10);
  endfunction

  function automatic logic is_reserved(input alu_cmd_e cmd);
    return (cmd[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_serial_digit_slice.sv
// alu_ripple_adder: W-bit ripple-carry adder.
//   a, b   - addends
//   ci     - carry in
//   sum    - W-bit sum
//   c_msb  - carry into bit W-1 (used for signed overflow)
//   co     - carry out of bit W-1
//
// alu_digit_slice: one DIGIT-wide slice of the serial ALU (combinational).
//   a_dig, b_dig - current digit of in1 / in2
//   ci           - carry from the previous digit
//   cmd          - latched command
//   res_dig      - result digit
//   co           - carry out of this digit (0 for non-arith commands)
//   c_msb        - carry into the digit's top bit (0 for non-arith commands)
module alu_ripple_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         c_msb,
  output logic         co
);

  logic [W:0] carry_s;

  // Bit-by-bit carry ripple from LSB to MSB.
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    carry_s[0] = ci;
    for (int i = 0; i < W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign c_msb = carry_s[W-1];
  assign co    = carry_s[W];

endmodule

module alu_digit_slice
  import alu_serial_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             ci,
  input  alu_cmd_e         cmd,
  output logic [DIGIT-1:0] res_dig,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT-1:0] b_sel_s;
  logic [DIGIT-1:0] sum_s;
  logic             add_c_msb_s;
  logic             add_co_s;

  // Second adder operand: cmd[2:1] picks 0 / in2 / ~in2 / all ones.
  always_comb begin
    b_sel_s = '0;
    case (cmd[2:1])
      2'b00:   b_sel_s = '0;
      2'b01:   b_sel_s = b_dig;
      2'b10:   b_sel_s = ~b_dig;
      2'b11:   b_sel_s = {DIGIT{1'b1}};
      default: b_sel_s = '0;
    endcase
  end

  alu_ripple_adder #(
    .W(DIGIT)
  ) u_adder (
    .a     (a_dig),
    .b     (b_sel_s),
    .ci    (ci),
    .sum   (sum_s),
    .c_msb (add_c_msb_s),
    .co    (add_co_s)
  );

  // Result select; carries are forced low outside the arithmetic group.
  always_comb begin
    res_dig = a_dig;
    co      = 1'b0;
    c_msb   = 1'b0;
    if (is_arith(cmd)) begin
      res_dig = sum_s;
      co      = add_co_s;
      c_msb   = add_c_msb_s;
    end else if (is_logic(cmd)) begin
      case (cmd)
        CMD_AND: res_dig = a_dig & b_dig;
        CMD_OR:  res_dig = a_dig | b_dig;
        CMD_XOR: res_dig = a_dig ^ b_dig;
        CMD_NOT: res_dig = ~a_dig;
        default: res_dig = a_dig;
      endcase
    end else begin
      // Reserved commands pass in1 through unchanged.
      res_dig = a_dig;
    end
  end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU, DIGIT bits per cycle, LSB digit first.
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - operation handshake; cmd/in1/in2 sampled on accept
//   cmd                  - alu_cmd_e
//   in1, in2             - WIDTH-bit operands
//   out_valid / out_ready- result handshake; result held until taken
//   out                  - WIDTH-bit result
//   co, ovf              - carry out / signed overflow (arith only)
//   zero, neg            - result == 0 / result MSB
//   err                  - a reserved command was executed
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("alu_serial: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_r;
  state_e           state_nxt_s;
  logic [DIG_W-1:0] dig_r;
  logic             carry_r;
  alu_cmd_e         cmd_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] out_r;
  logic             co_r;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;
  logic             err_r;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             accept_s;
  logic             last_dig_s;
  int               dig_base_s;
  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT-1:0] res_dig_s;
  logic             slice_co_s;
  logic             slice_c_msb_s;
  logic [WIDTH-1:0] res_full_s;

  assign accept_s   = in_valid & in_ready_s;
  assign last_dig_s = (dig_r == LAST_DIG);

  // Pick the current operand digits and splice the new result digit into
  // the running result so the flags see the complete word on the last digit.
  always_comb begin
    dig_base_s = int'(dig_r) * DIGIT;
    a_dig_s    = a_r[dig_base_s +: DIGIT];
    b_dig_s    = b_r[dig_base_s +: DIGIT];
    res_full_s = out_r;
    res_full_s[dig_base_s +: DIGIT] = res_dig_s;
  end

  alu_digit_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a_dig   (a_dig_s),
    .b_dig   (b_dig_s),
    .ci      (carry_r),
    .cmd     (cmd_r),
    .res_dig (res_dig_s),
    .co      (slice_co_s),
    .c_msb   (slice_c_msb_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a pop with a simultaneous push in DONE goes
  // straight back to RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_dig_s) state_nxt_s = DONE;
        else            state_nxt_s = RUN;
      end
      DONE: begin
        if (accept_s)       state_nxt_s = RUN;
        else if (out_ready) state_nxt_s = IDLE;
        else                state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: decode of the registered state plus out_ready only, gated
  // low while reset is asserted.
  always_comb begin
    out_valid_s = (state_r == DONE);
    if (!rst_n) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    end
  end

  // Operand capture, digit counter, carry chain and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_r   <= CMD_TRANSFER;
      a_r     <= '0;
      b_r     <= '0;
      dig_r   <= '0;
      carry_r <= 1'b0;
      out_r   <= '0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      cmd_r   <= alu_cmd_e'(cmd);
      a_r     <= in1;
      b_r     <= in2;
      dig_r   <= '0;
      // Initial carry is cmd[0] for arithmetic commands, 0 otherwise.
      carry_r <= cmd[0] & ~cmd[3];
    end else if (state_r == RUN) begin
      out_r   <= res_full_s;
      carry_r <= slice_co_s;
      if (last_dig_s) begin
        dig_r  <= '0;
        co_r   <= slice_co_s;
        ovf_r  <= slice_c_msb_s ^ slice_co_s;
        zero_r <= (res_full_s == '0);
        neg_r  <= res_full_s[WIDTH-1];
        err_r  <= is_reserved(cmd_r);
      end else begin
        dig_r  <= dig_r + DIG_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out       = out_r;
  assign co        = co_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign neg       = neg_r;
  assign err       = err_r;

endmodule
